// File: rtl/rv32_id_stage_if.sv
// rv32_id_stage_if: decode-stage bundle between IF/WB (inputs) and EX (outputs).
// The master side presents the instruction and write-back data; the slave
// side (the ID stage) returns the registered ID/EX payload.
interface rv32_id_stage_if #(
  parameter int XLEN = 32
);
  // IF / WB -> ID
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] wb_data;
  logic            reg_write_en;

  // ID -> EX (registered)
  logic [XLEN-1:0] mux_out_pcora;
  logic [XLEN-1:0] mux_out_borimm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_value;
  logic [XLEN-1:0] pc_value;
  logic [2:0]      func_data_out;
  logic [6:0]      func_7_out;
  logic [6:0]      op_code_out;
  logic [XLEN-1:0] linkreg;
  logic [XLEN-1:0] nextpc;
  logic [4:0]      rd_register;
  logic            branch_enable_out;
  logic            jal_en_out;
  logic            jalr_en_out;
  logic            mem_write_out;

  modport master (
    output instruction, pc, wb_data, reg_write_en,
    input  mux_out_pcora, mux_out_borimm, rs1_data, rs2_data, imm_value,
    input  pc_value, func_data_out, func_7_out, op_code_out, linkreg, nextpc,
    input  rd_register, branch_enable_out, jal_en_out, jalr_en_out, mem_write_out
  );

  modport slave (
    input  instruction, pc, wb_data, reg_write_en,
    output mux_out_pcora, mux_out_borimm, rs1_data, rs2_data, imm_value,
    output pc_value, func_data_out, func_7_out, op_code_out, linkreg, nextpc,
    output rd_register, branch_enable_out, jal_en_out, jalr_en_out, mem_write_out
  );
endinterface

// File: rtl/rv32_id_stage.sv
// rv32_id_stage: RV32I instruction decode stage.
// Register file (x0 hardwired zero, write-through bypass), immediate
// generator, control decoder, ALU operand muxes and jump/branch target
// adder, all captured in a single ID/EX output register (1-cycle latency).
// Optional macro ID_BRANCH_RESOLVE_EN: when defined, branch_enable_out is
// only raised when the funct3 condition holds on the bypassed operands;
// otherwise it is raised for every BRANCH opcode.
// XLEN is expected to be 32 (immediate formats are RV32 bit patterns).
module rv32_id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic             i_clk,
  input logic             i_rst,   // synchronous, active-low
  rv32_id_stage_if.slave  io_id
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction fields
  logic [31:0]     w_ins;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd_addr;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;

  assign w_ins      = io_id.instruction;
  assign w_opcode   = w_ins[6:0];
  assign w_rd_addr  = w_ins[11:7];
  assign w_funct3   = w_ins[14:12];
  assign w_rs1_addr = w_ins[19:15];
  assign w_rs2_addr = w_ins[24:20];
  assign w_funct7   = w_ins[31:25];

  // Register file storage; entry 0 is never written and never read.
  logic [XLEN-1:0] r_regs [NREGS];

  // Register file write port; reset clears every entry and wins over a write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (io_id.reg_write_en && (w_rd_addr != 5'd0)) begin
      r_regs[w_rd_addr] <= io_id.wb_data;
    end
  end

  // Read ports with x0 forcing and same-cycle write-through bypass
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  // Combinational rs1/rs2 read
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1_addr == 5'd0) begin
      w_rs1_val = '0;
    end else if (io_id.reg_write_en && (w_rd_addr == w_rs1_addr)) begin
      w_rs1_val = io_id.wb_data;
    end else begin
      w_rs1_val = r_regs[w_rs1_addr];
    end
    if (w_rs2_addr == 5'd0) begin
      w_rs2_val = '0;
    end else if (io_id.reg_write_en && (w_rd_addr == w_rs2_addr)) begin
      w_rs2_val = io_id.wb_data;
    end else begin
      w_rs2_val = r_regs[w_rs2_addr];
    end
  end

  // Control decode and immediate generation
  logic [XLEN-1:0] w_imm;
  logic            w_is_branch;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_store;

  // Opcode decode: per-format immediate and control flags (unknown -> all zero)
  always_comb begin
    w_imm       = '0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_is_store  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_imm = '0;
      end
      OP_IALU, OP_LOAD: begin
        w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      OP_JALR: begin
        w_imm     = {{20{w_ins[31]}}, w_ins[31:20]};
        w_is_jalr = 1'b1;
      end
      OP_STORE: begin
        w_imm      = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        w_is_store = 1'b1;
      end
      OP_BRANCH: begin
        w_imm       = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        w_is_branch = 1'b1;
      end
      OP_JAL: begin
        w_imm    = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
        w_is_jal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm = {w_ins[31:12], 12'b0};
      end
      default: begin
        w_imm = '0;
      end
    endcase
  end

  // Operand muxes and targets
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_link;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_rs1_imm;
  logic [XLEN-1:0] w_nextpc;

  assign w_link    = io_id.pc + XLEN'(4);
  assign w_pc_imm  = io_id.pc + w_imm;
  assign w_rs1_imm = w_rs1_val + w_imm;

  // ALU operand selection and next-PC selection
  always_comb begin
    w_opa    = w_rs1_val;
    w_opb    = w_imm;
    w_nextpc = w_link;
    case (w_opcode)
      OP_AUIPC, OP_JAL: w_opa = io_id.pc;
      OP_LUI:           w_opa = '0;
      default:          w_opa = w_rs1_val;
    endcase
    case (w_opcode)
      OP_R, OP_BRANCH: w_opb = w_rs2_val;
      default:         w_opb = w_imm;
    endcase
    case (w_opcode)
      OP_BRANCH, OP_JAL: w_nextpc = w_pc_imm;
      OP_JALR:           w_nextpc = {w_rs1_imm[XLEN-1:1], 1'b0};
      default:           w_nextpc = w_link;
    endcase
  end

  logic w_branch_en;
`ifdef ID_BRANCH_RESOLVE_EN
  logic w_cond;

  // Branch condition evaluated on the bypassed operands
  always_comb begin
    w_cond = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = (w_rs1_val == w_rs2_val);
      3'b001:  w_cond = (w_rs1_val != w_rs2_val);
      3'b100:  w_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_cond = (w_rs1_val <  w_rs2_val);
      3'b111:  w_cond = (w_rs1_val >= w_rs2_val);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_branch_en = w_is_branch & w_cond;
`else
  assign w_branch_en = w_is_branch;
`endif

  // ID/EX pipeline register
  logic [XLEN-1:0] r_opa, r_opb, r_rs1, r_rs2, r_imm, r_pc, r_link, r_nextpc;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [6:0]      r_opcode;
  logic [4:0]      r_rd;
  logic            r_branch, r_jal, r_jalr, r_store;

  // Capture all decode results; reset drives the whole payload to zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_link   <= '0;
      r_nextpc <= '0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_opcode <= 7'd0;
      r_rd     <= 5'd0;
      r_branch <= 1'b0;
      r_jal    <= 1'b0;
      r_jalr   <= 1'b0;
      r_store  <= 1'b0;
    end else begin
      r_opa    <= w_opa;
      r_opb    <= w_opb;
      r_rs1    <= w_rs1_val;
      r_rs2    <= w_rs2_val;
      r_imm    <= w_imm;
      r_pc     <= io_id.pc;
      r_link   <= w_link;
      r_nextpc <= w_nextpc;
      r_funct3 <= w_funct3;
      r_funct7 <= w_funct7;
      r_opcode <= w_opcode;
      r_rd     <= w_rd_addr;
      r_branch <= w_branch_en;
      r_jal    <= w_is_jal;
      r_jalr   <= w_is_jalr;
      r_store  <= w_is_store;
    end
  end

  assign io_id.mux_out_pcora     = r_opa;
  assign io_id.mux_out_borimm    = r_opb;
  assign io_id.rs1_data          = r_rs1;
  assign io_id.rs2_data          = r_rs2;
  assign io_id.imm_value         = r_imm;
  assign io_id.pc_value          = r_pc;
  assign io_id.func_data_out     = r_funct3;
  assign io_id.func_7_out        = r_funct7;
  assign io_id.op_code_out       = r_opcode;
  assign io_id.linkreg           = r_link;
  assign io_id.nextpc            = r_nextpc;
  assign io_id.rd_register       = r_rd;
  assign io_id.branch_enable_out = r_branch;
  assign io_id.jal_en_out        = r_jal;
  assign io_id.jalr_en_out       = r_jalr;
  assign io_id.mem_write_out     = r_store;

endmodule

// File: tb/tb_rv32_id_stage.sv
// tb_rv32_id_stage: directed table plus randomized checks of rv32_id_stage
// against a behavioural decode model kept in this file.
module tb_rv32_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rv32_id_stage_if #(.XLEN(32)) u_if ();

  rv32_id_stage #(.XLEN(32), .NREGS(32)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_id (u_if.slave)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] mregs [32];

  typedef struct {
    logic [31:0] rs1, rs2, imm, opa, opb, npc, link, pcv;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [4:0]  rd;
    logic        br, jal, jalr, mw;
  } exp_t;

  typedef struct {
    logic [31:0] ins, pc, wb;
    logic        we;
    logic [31:0] e_rs1, e_rs2, e_imm, e_opa, e_opb, e_npc;
    logic [3:0]  e_flags;   // {branch, jal, jalr, store}
    logic [4:0]  e_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic [4:0] rd,
                                           input logic we, input logic [31:0] wb);
    if (a == 5'd0) return 32'd0;
    if (we && a == rd) return wb;
    return mregs[a];
  endfunction

  // Reference decode: immediates built with plain arithmetic from the field rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] wb, input logic we);
    exp_t e;
    logic [6:0] op;
    logic       cond;
    op     = ins[6:0];
    e.rs1  = rd_model(ins[19:15], ins[11:7], we, wb);
    e.rs2  = rd_model(ins[24:20], ins[11:7], we, wb);
    e.pcv  = pc;
    e.link = pc + 32'd4;
    e.f3   = ins[14:12];
    e.f7   = ins[31:25];
    e.op   = op;
    e.rd   = ins[11:7];
    e.br = 1'b0; e.jal = 1'b0; e.jalr = 1'b0; e.mw = 1'b0;
    e.imm = 32'd0;
    case (op)
      7'h13, 7'h03, 7'h67:
        e.imm = (ins[31] ? 32'hFFFF_F800 : 32'd0) + 32'(ins[30:20]);
      7'h23:
        e.imm = (ins[31] ? 32'hFFFF_F800 : 32'd0) + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:7]);
      7'h63:
        e.imm = (ins[31] ? 32'hFFFF_F000 : 32'd0) + 32'(ins[7]) * 32'd2048
              + 32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
      7'h6F:
        e.imm = (ins[31] ? 32'hFFF0_0000 : 32'd0) + 32'(ins[19:12]) * 32'd4096
              + 32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2;
      7'h37, 7'h17:
        e.imm = 32'(ins[31:12]) * 32'd4096;
      default: e.imm = 32'd0;
    endcase
    e.opa = (op == 7'h17 || op == 7'h6F) ? pc : (op == 7'h37) ? 32'd0 : e.rs1;
    e.opb = (op == 7'h33 || op == 7'h63) ? e.rs2 : e.imm;
    if (op == 7'h63 || op == 7'h6F)  e.npc = pc + e.imm;
    else if (op == 7'h67)            e.npc = (e.rs1 + e.imm) & 32'hFFFF_FFFE;
    else                             e.npc = pc + 32'd4;
    e.mw   = (op == 7'h23);
    e.jal  = (op == 7'h6F);
    e.jalr = (op == 7'h67);
`ifdef ID_BRANCH_RESOLVE_EN
    case (ins[14:12])
      3'd0:    cond = (e.rs1 == e.rs2);
      3'd1:    cond = (e.rs1 != e.rs2);
      3'd4:    cond = ($signed(e.rs1) <  $signed(e.rs2));
      3'd5:    cond = ($signed(e.rs1) >= $signed(e.rs2));
      3'd6:    cond = (e.rs1 <  e.rs2);
      3'd7:    cond = (e.rs1 >= e.rs2);
      default: cond = 1'b0;
    endcase
`else
    cond = 1'b1;
`endif
    e.br = (op == 7'h63) && cond;
    return e;
  endfunction

  task automatic check_all(input exp_t e, input string t);
    chk({t, " opa"},  u_if.mux_out_pcora,  e.opa);
    chk({t, " opb"},  u_if.mux_out_borimm, e.opb);
    chk({t, " rs1"},  u_if.rs1_data,       e.rs1);
    chk({t, " rs2"},  u_if.rs2_data,       e.rs2);
    chk({t, " imm"},  u_if.imm_value,      e.imm);
    chk({t, " pc"},   u_if.pc_value,       e.pcv);
    chk({t, " f3"},   32'(u_if.func_data_out), 32'(e.f3));
    chk({t, " f7"},   32'(u_if.func_7_out),    32'(e.f7));
    chk({t, " op"},   32'(u_if.op_code_out),   32'(e.op));
    chk({t, " link"}, u_if.linkreg,        e.link);
    chk({t, " npc"},  u_if.nextpc,         e.npc);
    chk({t, " rd"},   32'(u_if.rd_register), 32'(e.rd));
    chk({t, " flags"},
        32'({u_if.branch_enable_out, u_if.jal_en_out, u_if.jalr_en_out, u_if.mem_write_out}),
        32'({e.br, e.jal, e.jalr, e.mw}));
  endtask

  task automatic check_zero(input string t);
    exp_t z;
    z = '{default: '0};
    check_all(z, t);
  endtask

  // One decode cycle: drive at negedge, sample 1 time unit after the posedge
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] wb,
                      input logic we, input string t);
    exp_t e;
    @(negedge clk);
    u_if.instruction  = ins;
    u_if.pc           = pc;
    u_if.wb_data      = wb;
    u_if.reg_write_en = we;
    e = model(ins, pc, wb, we);
    @(posedge clk);
    #1;
    check_all(e, t);
    if (we && ins[11:7] != 5'd0) mregs[ins[11:7]] = wb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    u_if.instruction  = 32'h0050_0293;   // ADDI x5,x0,5 with a write attempt
    u_if.pc           = 32'h0000_1234;
    u_if.wb_data      = 32'hFFFF_FFFF;
    u_if.reg_write_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    u_if.reg_write_en = 1'b0;
  endtask

  task automatic read_all_zero(input string t);
    logic [31:0] ins;
    for (int i = 1; i < 32; i++) begin
      ins = (32'(i) << 20) | (32'(i) << 15) | 32'h33;
      step(ins, 32'd0, 32'd0, 1'b0, t);
      chk({t, " xi"}, u_if.rs1_data | u_if.rs2_data, 32'd0);
    end
  endtask

  vec_t        tbl [15];
  logic [6:0]  ops [10];
  logic [31:0] r;

  initial begin
    u_if.instruction  = 32'd0;
    u_if.pc           = 32'd0;
    u_if.wb_data      = 32'd0;
    u_if.reg_write_en = 1'b0;
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;

    //           ins           pc            wb            we    rs1           rs2           imm           opa           opb           npc           flags    rd
    tbl[0]  = '{32'h0000_0313, 32'h0000_0000, 32'h0000_0011, 1'b1, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h4,       4'b0000, 5'd6};
    tbl[1]  = '{32'h0073_02B3, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h11,      32'h0,       32'h0,       32'h11,      32'h0,       32'h8,       4'b0000, 5'd5};
    tbl[2]  = '{32'h0000_0013, 32'h0000_0008, 32'h0000_DEAD, 1'b1, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'hC,       4'b0000, 5'd0};
    tbl[3]  = '{32'h0000_00B3, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h10,      4'b0000, 5'd1};
    tbl[4]  = '{32'h0241_8163, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'd34,      32'h0,       32'h0,       32'h122,     4'b1000, 5'd2};
    tbl[5]  = '{32'h0021_AAA3, 32'h0000_0104, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'd21,      32'h0,       32'd21,      32'h108,     4'b0001, 5'd21};
    tbl[6]  = '{32'h0000_0093, 32'h0000_0108, 32'h0000_0305, 1'b1, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h10C,     4'b0000, 5'd1};
    tbl[7]  = '{32'h0000_106F, 32'h0000_0200, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'h1000,    32'h200,     32'h1000,    32'h1200,    4'b0100, 5'd0};
    tbl[8]  = '{32'h0000_8167, 32'h0000_0300, 32'h0000_0000, 1'b0, 32'h305,     32'h0,       32'h0,       32'h305,     32'h0,       32'h304,     4'b0010, 5'd2};
    tbl[9]  = '{32'h0050_0013, 32'h0000_0304, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'd5,       32'h0,       32'd5,       32'h308,     4'b0000, 5'd0};
    tbl[10] = '{32'h0003_8393, 32'h0000_0400, 32'h0000_0ABC, 1'b1, 32'hABC,     32'h0,       32'h0,       32'hABC,     32'h0,       32'h404,     4'b0000, 5'd7};
    tbl[11] = '{32'hFFFF_F437, 32'h0000_0500, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'hFFFFF000, 32'h0,      32'hFFFFF000, 32'h504,    4'b0000, 5'd8};
    tbl[12] = '{32'h0000_1497, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'h1000,    32'hFFFFFFFC, 32'h1000,   32'h0,       4'b0000, 5'd9};
    tbl[13] = '{32'h0000_007F, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,       32'h14,      4'b0000, 5'd0};
    tbl[14] = '{32'hFE13_9EE3, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hABC,     32'h305,     32'hFFFFFFFC, 32'hABC,    32'h305,     32'hFFFFFFFC, 4'b1000, 5'd29};

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

    do_reset();
    read_all_zero("post-reset");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].ins, tbl[i].pc, tbl[i].wb, tbl[i].we, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d rs1", i), u_if.rs1_data, tbl[i].e_rs1);
      chk($sformatf("tbl%0d rs2", i), u_if.rs2_data, tbl[i].e_rs2);
      chk($sformatf("tbl%0d imm", i), u_if.imm_value, tbl[i].e_imm);
      chk($sformatf("tbl%0d opa", i), u_if.mux_out_pcora, tbl[i].e_opa);
      chk($sformatf("tbl%0d opb", i), u_if.mux_out_borimm, tbl[i].e_opb);
      chk($sformatf("tbl%0d npc", i), u_if.nextpc, tbl[i].e_npc);
      chk($sformatf("tbl%0d link", i), u_if.linkreg, tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d flags", i),
          32'({u_if.branch_enable_out, u_if.jal_en_out, u_if.jalr_en_out, u_if.mem_write_out}),
          32'(tbl[i].e_flags));
      chk($sformatf("tbl%0d rd", i), 32'(u_if.rd_register), 32'(tbl[i].e_rd));
    end

    // Randomized decode with frequent rd==rs1/rs2 collisions to exercise bypass
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 9)];
      if (n % 10 == 9) r[6:0] = 7'($urandom());
      if ($urandom_range(0, 3) == 0) r[19:15] = r[11:7];
      if ($urandom_range(0, 5) == 0) r[24:20] = r[11:7];
      if ($urandom_range(0, 4) == 0) r[24:20] = r[19:15];
      step(r, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    do_reset();
    read_all_zero("re-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
